dmem_port_ctrl: RTL and testbench

Sequential data-memory port controller for the memory stage. It sits between the store lane-formatting logic and the load extraction logic. It accepts one load or store request per memory instruction, runs a valid/grant/rvalid handshake to the data memory, and stalls the pipeline while the access is in flight. It returns the raw 32-bit word that the load extractor sign- or zero-extends. Only one access is outstanding at any time.

---
 rtl/dmem_port_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_ctrl.sv
// Data-memory port controller for the memory stage: one outstanding load or store,
// valid/grant/rvalid handshake, pipeline stall while busy, timeout abort with error.
module dmem_port_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_s;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  be_r;
    logic [15:0] cnt_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic        expired_s;
    logic        abort_s;
    logic        load_ok_s;
    logic        busy_s;

    assign expired_s = (cnt_r == CNT_LAST);
    assign busy_s    = (state_r == ST_REQ) || (state_r == ST_WAIT);

    // Next-state selection and completion classification
    always_comb begin
        state_s   = state_r;
        abort_s   = 1'b0;
        load_ok_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    state_s = we_r ? ST_DONE : ST_WAIT;
                end else if (expired_s) begin
                    state_s = ST_DONE;
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_s   = ST_DONE;
                    load_ok_s = 1'b1;
                end else if (expired_s) begin
                    state_s = ST_DONE;
                    abort_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request latch, timeout counter and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            be_r    <= 4'd0;
            cnt_r   <= 16'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_IDLE) && req_valid) begin
                we_r    <= req_we;
                addr_r  <= {req_addr[31:2], 2'b00};
                wdata_r <= req_wdata;
                be_r    <= req_we ? req_be : 4'b1111;
            end else begin
                we_r    <= we_r;
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                be_r    <= be_r;
            end
            // Entering REQ or WAIT restarts the count; it only advances while busy
            if ((state_s != state_r) && ((state_s == ST_REQ) || (state_s == ST_WAIT))) begin
                cnt_r <= 16'd0;
            end else if (busy_s) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            if (abort_s) begin
                rdata_r <= 32'd0;
            end else if (load_ok_s) begin
                rdata_r <= mem_rdata;
            end else begin
                rdata_r <= rdata_r;
            end
            if (state_s == ST_DONE) begin
                err_r <= abort_s;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Output decode; memory-side fields are forced to zero when no request is driven
    always_comb begin
        stall     = 1'b0;
        rsp_valid = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        case (state_r)
            ST_IDLE: begin
                stall = req_valid;
            end
            ST_REQ: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_r;
                mem_addr  = addr_r;
                mem_wdata = wdata_r;
                mem_be    = be_r;
            end
            ST_WAIT: begin
                stall = 1'b1;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl: expected completions are queued at issue time and
// a negedge monitor checks every rsp_valid pulse against the queue head.
module tb_dmem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    int pulses = 0;
    int expected_pulses = 0;
    logic [32:0] exp_q[$];

    dmem_port_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic err, input logic [31:0] rdata);
        exp_q.push_back({err, rdata});
        expected_pulses++;
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            logic [32:0] e;
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=0x%08h expected no pulse", rsp_err, rsp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    failures++;
                    $display("FAIL rsp_data: got err=%0b rdata=0x%08h expected err=%0b rdata=0x%08h",
                             rsp_err, rsp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_be = 4'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        step(); step();
        chk("reset_ctrl", {26'd0, stall, rsp_valid, rsp_err, mem_req, mem_we, 1'b0}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        chk("reset_mem", mem_addr | mem_wdata | {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;

        // Store SB, zero-wait
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_1006;
        req_be = 4'b0100; req_wdata = 32'h5A5A_5A5A; mem_gnt = 1'b1;
        expect_rsp(1'b0, 32'd0);
        #1;
        chk("sb_c0_stall", {31'd0, stall}, 32'd1);
        chk("sb_c0_req", {31'd0, mem_req}, 32'd0);
        step();
        chk("sb_c1_ctrl", {29'd0, stall, mem_req, mem_we}, 32'd7);
        chk("sb_c1_addr", mem_addr, 32'h0000_1004);
        chk("sb_c1_be", {28'd0, mem_be}, 32'h4);
        chk("sb_c1_wdata", mem_wdata, 32'h5A5A_5A5A);
        step();
        chk("sb_c2_done", {30'd0, stall, rsp_valid}, 32'd1);
        req_valid = 1'b0; mem_gnt = 1'b0;
        step();
        chk("idle_mem_zero", mem_addr | mem_wdata | {27'd0, mem_we, mem_be}, 32'd0);

        // Stray rvalid in IDLE
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        chk("stray_idle_rdata", rsp_rdata, 32'd0);

        // Load, grant two cycles late, rvalid three cycles after grant
        mem_rvalid = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_2002; req_be = 4'b0001;
        expect_rsp(1'b0, 32'hDEAD_BEEF);
        step();
        chk("ld_c1_ctrl", {27'd0, mem_req, mem_we, mem_be}, {27'd0, 1'b1, 1'b0, 4'b1111});
        chk("ld_c1_addr", mem_addr, 32'h0000_2000);
        step();
        step();
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("ld_wait_ctrl", {30'd0, stall, mem_req}, 32'h2);
        step();
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("ld_done_stall", {30'd0, stall, rsp_valid}, 32'd1);
        req_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        for (int i = 0; i < 5; i++) step();
        chk("ld_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);
        chk("pulses_after_ld", pulses, 32'd2);

        // Timeout with grant stuck low
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_3000;
        expect_rsp(1'b1, 32'd0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mem_req) n++;
            if (rsp_valid) break;
        end
        chk("to_req_cycles", n, 32'd8);
        chk("to_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        req_valid = 1'b0;
        step();

        // Store after timeout clears the error
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0010; req_be = 4'b1111;
        req_wdata = 32'h0102_0304; mem_gnt = 1'b1;
        expect_rsp(1'b0, 32'd0);
        step(); step();
        chk("st2_done", {30'd0, rsp_valid, rsp_err}, 32'h2);
        req_valid = 1'b0; mem_gnt = 1'b0;
        step();

        // Zero-wait load: completes in cycle3
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040; mem_gnt = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        expect_rsp(1'b0, 32'hCAFE_F00D);
        step();
        mem_rdata = 32'h0BAD_0BAD;
        step();
        mem_rdata = 32'hCAFE_F00D;
        step();
        chk("zw_ld_c3", {31'd0, rsp_valid}, 32'd1);
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step();

        // Reset in the middle of WAIT
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0080;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; rst_n = 1'b0; req_valid = 1'b0;
        step();
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        chk("rst_mid_ctrl", {26'd0, stall, rsp_valid, rsp_err, mem_req, mem_we, 1'b0}, 32'd0);
        chk("rst_mid_rdata", rsp_rdata, 32'd0);
        step();
        mem_rvalid = 1'b0;
        chk("rst_late_rvalid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_late_rdata", rsp_rdata, 32'd0);

        // Back-to-back load then store with req_valid held high
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4008;
        expect_rsp(1'b0, 32'h0BAD_F00D);
        expect_rsp(1'b0, 32'h0BAD_F00D);
        step(); step(); step();
        chk("b2b_first_done", {30'd0, rsp_valid, mem_req}, 32'h2);
        step();
        req_we = 1'b1; req_addr = 32'h0000_5000; req_be = 4'b1111; req_wdata = 32'h1122_3344;
        mem_rdata = 32'hEEEE_EEEE;
        #1;
        chk("b2b_idle_gap", {30'd0, stall, mem_req}, 32'h2);
        step();
        chk("b2b_st_req", {30'd0, mem_req, mem_we}, 32'h3);
        chk("b2b_st_addr", mem_addr, 32'h0000_5000);
        step();
        chk("b2b_second_done", {31'd0, rsp_valid}, 32'd1);
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step(); step();

        chk("pulse_total", pulses, expected_pulses);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
